alu_muldiv_controller: RTL and testbench

Multi-cycle sequencer for the MUL, DIV and MOD operations, which the single-cycle ALU does not implement.
- Accepts one operation at a time on a start/busy/done handshake.
- Runs an iterative shift-add multiply or restoring divide over WIDTH cycles and presents a registered result.
- Sits beside the ALU. The control unit routes MUL_e/DIV_e/MOD_e requests here and stalls on busy.

---
 rtl/alu_muldiv_controller.sv | 85 ++++++++
 tb/tb_alu_muldiv_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_controller.sv
// alu_muldiv_controller: multi-cycle MUL/DIV/MOD sequencer beside the ALU (shift-add / restoring divide).
// Define ALU_MULDIV_SIGNED_EN to add the op_signed input for two's-complement operation.
module alu_muldiv_controller #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
`ifdef ALU_MULDIV_SIGNED_EN
   input  logic             op_signed,
`endif
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_next;
   logic [1:0] op_q;
   logic [WIDTH-1:0] acc, acc_next, sa, sa_next, sb, sb_next, mag1, mag2, raw, res_final;
   logic [WIDTH:0] shifted, diff;
   logic [CW-1:0] cnt;
   logic neg, s1, s2, zero_div, last;
`ifdef ALU_MULDIV_SIGNED_EN
   assign s1 = op_signed & operand1[WIDTH-1];
   assign s2 = op_signed & operand2[WIDTH-1];
`else
   assign s1 = 1'b0;
   assign s2 = 1'b0;
`endif
   assign mag1 = s1 ? ~operand1 + WIDTH'(1) : operand1;
   assign mag2 = s2 ? ~operand2 + WIDTH'(1) : operand2;
   assign zero_div = (op == 2'b01 || op == 2'b10) && operand2 == '0;
   assign last = cnt == CW'(WIDTH - 1);
   assign busy = state != IDLE;
   assign done = state == DONE;
   // sa holds multiplicand (MUL) or dividend shifting into quotient (DIV/MOD); acc is product or remainder
   always_comb begin
      shifted = {acc, sa[WIDTH-1]};
      diff = shifted - {1'b0, sb};
      acc_next = op_q == 2'b00 ? acc + (sb[0] ? sa : '0) : (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]);
      sa_next = op_q == 2'b00 ? sa << 1 : {sa[WIDTH-2:0], ~diff[WIDTH]};
      sb_next = op_q == 2'b00 ? sb >> 1 : sb;
      raw = op_q == 2'b01 ? sa_next : acc_next;
      res_final = neg ? ~raw + WIDTH'(1) : raw;
      state_next = state == IDLE ? (start ? ((op == 2'b11 || zero_div) ? DONE : RUN) : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         op_q <= '0;
         acc <= '0;
         sa <= '0;
         sb <= '0;
         cnt <= '0;
         neg <= 1'b0;
         result <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            op_q <= op;
            sa <= mag1;
            sb <= mag2;
            acc <= '0;
            cnt <= '0;
            neg <= op == 2'b10 ? s1 : s1 ^ s2;
            div_by_zero <= zero_div;
            if (zero_div) result <= op == 2'b01 ? '1 : operand1;
            else if (op == 2'b11) result <= '0;
         end else if (state == RUN) begin
            acc <= acc_next;
            sa <= sa_next;
            sb <= sb_next;
            cnt <= cnt + CW'(1);
            if (last) result <= res_final;
         end
      end
   end
endmodule

// File: tb/tb_alu_muldiv_controller.sv
// tb_alu_muldiv_controller: directed self-checking bench for the MUL/DIV/MOD sequencer.
module tb_alu_muldiv_controller;
   localparam logic [1:0] MUL = 2'b00, DIV = 2'b01, MOD = 2'b10, RSV = 2'b11;
   logic clk = 1'b0, rst_n, start, op_signed;
   logic [1:0] op;
   logic [31:0] operand1, operand2, result;
   logic busy, done, div_by_zero;
   int checks = 0, failures = 0;
   typedef struct {
      logic [1:0] o;
      logic [31:0] a, b, e;
      logic z;
      int l;
   } vec_t;
   vec_t ops_tbl [17] = '{
      '{MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33},
      '{MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 33},
      '{MUL, 32'd0, 32'd5, 32'd0, 1'b0, 33},
      '{MUL, 32'd12345, 32'd0, 32'd0, 1'b0, 33},
      '{MUL, 32'd10000, 32'd10000, 32'h05F5E100, 1'b0, 33},
      '{MUL, 32'h00010000, 32'h00010000, 32'd0, 1'b0, 33},
      '{DIV, 32'd100, 32'd7, 32'd14, 1'b0, 33},
      '{MOD, 32'd100, 32'd7, 32'd2, 1'b0, 33},
      '{DIV, 32'd7, 32'd100, 32'd0, 1'b0, 33},
      '{MOD, 32'd7, 32'd100, 32'd7, 1'b0, 33},
      '{DIV, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 33},
      '{DIV, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 33},
      '{DIV, 32'h80000000, 32'd3, 32'h2AAAAAAA, 1'b0, 33},
      '{MOD, 32'h80000000, 32'd3, 32'd2, 1'b0, 33},
      '{DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1},
      '{MOD, 32'd5, 32'd0, 32'd5, 1'b1, 1},
      '{RSV, 32'd9, 32'd9, 32'd0, 1'b0, 1}
   };

   alu_muldiv_controller #(.WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .op(op),
`ifdef ALU_MULDIV_SIGNED_EN
      .op_signed(op_signed),
`endif
      .operand1(operand1),
      .operand2(operand2),
      .busy(busy),
      .done(done),
      .result(result),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Issues one request from a negedge and follows it until done, then samples the next (IDLE) cycle
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output logic [31:0] res, output logic dz, output logic bsy,
                         output logic dn_next, output logic bsy_next, output logic dz_next);
      op = o;
      operand1 = a;
      operand2 = b;
      op_signed = s;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      operand1 = ~a;
      operand2 = ~b;
      lat = 1;
      bsy = busy;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      res = result;
      dz = div_by_zero;
      @(negedge clk);
      dn_next = done;
      bsy_next = busy;
      dz_next = div_by_zero;
   endtask

   task automatic test_reset;
      #2;
      checks += 4;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      if (result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
      if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
   endtask

   task automatic test_ops;
      int lat;
      logic [31:0] res;
      logic dz, bsy, dn, bn, dzn;
      for (int i = 0; i < 17; i++) begin
         run_op(ops_tbl[i].o, ops_tbl[i].a, ops_tbl[i].b, 1'b0, lat, res, dz, bsy, dn, bn, dzn);
         checks += 7;
         if (res !== ops_tbl[i].e) begin failures++; $display("FAIL op%0d_result: got %h expected %h", i, res, ops_tbl[i].e); end
         if (lat != ops_tbl[i].l) begin failures++; $display("FAIL op%0d_latency: got %0d expected %0d", i, lat, ops_tbl[i].l); end
         if (dz !== ops_tbl[i].z) begin failures++; $display("FAIL op%0d_dbz: got %b expected %b", i, dz, ops_tbl[i].z); end
         if (dzn !== ops_tbl[i].z) begin failures++; $display("FAIL op%0d_dbz_hold: got %b expected %b", i, dzn, ops_tbl[i].z); end
         if (bsy !== 1'b1) begin failures++; $display("FAIL op%0d_busy: got %b expected 1", i, bsy); end
         if (dn !== 1'b0) begin failures++; $display("FAIL op%0d_done_width: got %b expected 0", i, dn); end
         if (bn !== 1'b0) begin failures++; $display("FAIL op%0d_busy_after: got %b expected 0", i, bn); end
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [31:0] res;
      logic dz, bsy, dn, bn, dzn;
      run_op(MUL, 32'd3, 32'd5, 1'b0, lat, res, dz, bsy, dn, bn, dzn);
      checks += 1;
      if (res !== 32'd15) begin failures++; $display("FAIL b2b_first: got %h expected %h", res, 32'd15); end
      run_op(DIV, 32'd15, 32'd4, 1'b0, lat, res, dz, bsy, dn, bn, dzn);
      checks += 2;
      if (lat != 33) begin failures++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
      if (res !== 32'd3) begin failures++; $display("FAIL b2b_second: got %h expected %h", res, 32'd3); end
   endtask

   task automatic test_ignore;
      int first = 0, ndone = 0;
      logic [31:0] res = '0;
      op = MUL;
      operand1 = 32'd7;
      operand2 = 32'd6;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (done) begin
            ndone++;
            if (first == 0) begin first = k; res = result; end
         end
         start = (k == 10 || k == 33);
         operand1 = 32'd9;
         operand2 = 32'd9;
         @(negedge clk);
      end
      start = 1'b0;
      checks += 3;
      if (first != 33) begin failures++; $display("FAIL ignore_latency: got %0d expected 33", first); end
      if (ndone != 1) begin failures++; $display("FAIL ignore_pulses: got %0d expected 1", ndone); end
      if (res !== 32'd42) begin failures++; $display("FAIL ignore_result: got %h expected %h", res, 32'd42); end
   endtask

   task automatic test_reset_mid;
      int ndone = 0, lat;
      logic [31:0] res;
      logic dz, bsy, dn, bn, dzn;
      op = DIV;
      operand1 = 32'd1000;
      operand2 = 32'd3;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", done); end
      if (result !== 32'd0) begin failures++; $display("FAIL midrst_result: got %h expected 0", result); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      checks += 1;
      if (ndone != 0) begin failures++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
      run_op(MUL, 32'd3, 32'd3, 1'b0, lat, res, dz, bsy, dn, bn, dzn);
      checks += 2;
      if (res !== 32'd9) begin failures++; $display("FAIL midrst_mul: got %h expected %h", res, 32'd9); end
      if (lat != 33) begin failures++; $display("FAIL midrst_latency: got %0d expected 33", lat); end
   endtask

`ifdef ALU_MULDIV_SIGNED_EN
   vec_t sgn_tbl [10] = '{
      '{DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33},
      '{MOD, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 33},
      '{MUL, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFF4, 1'b0, 33},
      '{MUL, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'd12, 1'b0, 33},
      '{DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33},
      '{MOD, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 33},
      '{DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33},
      '{MOD, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, 33},
      '{DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1'b1, 1},
      '{MOD, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1'b1, 1}
   };
   task automatic test_signed;
      int lat;
      logic [31:0] res;
      logic dz, bsy, dn, bn, dzn;
      for (int i = 0; i < 10; i++) begin
         run_op(sgn_tbl[i].o, sgn_tbl[i].a, sgn_tbl[i].b, 1'b1, lat, res, dz, bsy, dn, bn, dzn);
         checks += 3;
         if (res !== sgn_tbl[i].e) begin failures++; $display("FAIL sgn%0d_result: got %h expected %h", i, res, sgn_tbl[i].e); end
         if (lat != sgn_tbl[i].l) begin failures++; $display("FAIL sgn%0d_latency: got %0d expected %0d", i, lat, sgn_tbl[i].l); end
         if (dz !== sgn_tbl[i].z) begin failures++; $display("FAIL sgn%0d_dbz: got %b expected %b", i, dz, sgn_tbl[i].z); end
      end
      run_op(DIV, 32'hFFFFFFF9, 32'd2, 1'b0, lat, res, dz, bsy, dn, bn, dzn);
      checks += 1;
      if (res !== 32'h7FFFFFFC) begin failures++; $display("FAIL sgn_unsigned_div: got %h expected %h", res, 32'h7FFFFFFC); end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op = MUL;
      op_signed = 1'b0;
      operand1 = '0;
      operand2 = '0;
      test_reset;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_ops;
      test_back_to_back;
      test_ignore;
      test_reset_mid;
`ifdef ALU_MULDIV_SIGNED_EN
      test_signed;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
